// File: rtl/axi_write_arbiter_if.sv
// One AXI3 write channel bundle (AW, W, B) shared by the arbiter's slave and master ports.
// Handshake rule: a beat moves on a rising edge when valid and ready are both high; the side
// asserting valid keeps its payload stable until that beat.
interface axi_write_arbiter_if #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [3:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic [3:0]                  awcache;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_ID_WIDTH-1:0]     wid;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic                        wvalid;
    logic                        wready;
    logic                        bvalid;
    logic                        bready;

    modport master (
        output awid, awlen, awsize, awburst, awcache, awaddr, awvalid,
        input  awready,
        output wid, wstrb, wlast, wdata, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  awid, awlen, awsize, awburst, awcache, awaddr, awvalid,
        output awready,
        input  wid, wstrb, wlast, wdata, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// Two-slave to one-master AXI3 write arbiter: round-robin AW into a register stage,
// W and B steered by order queues recording which slave owns each outstanding burst.
module axi_write_arbiter #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi_write_arbiter_if.slave  s0_axi,
    axi_write_arbiter_if.slave  s1_axi,
    axi_write_arbiter_if.master m_axi
);
    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int CW  = PW + 1;
    localparam int AWW = AXI_ID_WIDTH + 13 + AXI_ADDR_WIDTH;

    logic                   aw_valid_q, aw_valid_d;
    logic [AWW-1:0]         aw_q, aw_d;
    logic                   prio_q, prio_d;
    logic [CW-1:0]          out_cnt_q, out_cnt_d;
    logic [QUEUE_DEPTH-1:0] wq_mem_q, wq_mem_d, bq_mem_q, bq_mem_d;
    logic [PW-1:0]          wq_rd_q, wq_rd_d, wq_wr_q, wq_wr_d;
    logic [PW-1:0]          bq_rd_q, bq_rd_d, bq_wr_q, bq_wr_d;
    logic [CW-1:0]          wq_cnt_q, wq_cnt_d, bq_cnt_q, bq_cnt_d;

    logic           grant, aw_acc;
    logic           w_ne, w_head, w_vld, w_last, w_pop;
    logic           b_ne, b_head, b_rdy, b_pop;
    logic [AWW-1:0] s0_aw, s1_aw;

    assign s0_aw = {s0_axi.awid, s0_axi.awlen, s0_axi.awsize, s0_axi.awburst,
                    s0_axi.awcache, s0_axi.awaddr};
    assign s1_aw = {s1_axi.awid, s1_axi.awlen, s1_axi.awsize, s1_axi.awburst,
                    s1_axi.awcache, s1_axi.awaddr};

    always_comb begin
        // prio_q names the slave that wins a tie; a lone requester always wins
        grant  = (s0_axi.awvalid && s1_axi.awvalid) ? prio_q : s1_axi.awvalid;
        aw_acc = aresetn && (s0_axi.awvalid || s1_axi.awvalid) &&
                 (!aw_valid_q || m_axi.awready) && (out_cnt_q < CW'(QUEUE_DEPTH));
        w_ne   = (wq_cnt_q != '0);
        w_head = wq_mem_q[wq_rd_q];
        w_vld  = w_ne && (w_head ? s1_axi.wvalid : s0_axi.wvalid);
        w_last = w_head ? s1_axi.wlast : s0_axi.wlast;
        w_pop  = w_vld && m_axi.wready && w_last;
        b_ne   = (bq_cnt_q != '0);
        b_head = bq_mem_q[bq_rd_q];
        b_rdy  = b_ne && (b_head ? s1_axi.bready : s0_axi.bready);
        b_pop  = b_rdy && m_axi.bvalid;
    end

    always_comb begin
        aw_valid_d = aw_valid_q;
        aw_d       = aw_q;
        prio_d     = prio_q;
        wq_mem_d   = wq_mem_q;
        wq_rd_d    = wq_rd_q;
        wq_wr_d    = wq_wr_q;
        bq_mem_d   = bq_mem_q;
        bq_rd_d    = bq_rd_q;
        bq_wr_d    = bq_wr_q;
        if (aw_acc) begin
            aw_valid_d        = 1'b1;
            aw_d              = grant ? s1_aw : s0_aw;
            prio_d            = ~grant;
            wq_mem_d[wq_wr_q] = grant;
            wq_wr_d           = wq_wr_q + PW'(1);
        end else if (m_axi.awready) begin
            aw_valid_d = 1'b0;
        end
        if (w_pop) begin
            wq_rd_d           = wq_rd_q + PW'(1);
            bq_mem_d[bq_wr_q] = w_head;
            bq_wr_d           = bq_wr_q + PW'(1);
        end
        if (b_pop) begin
            bq_rd_d = bq_rd_q + PW'(1);
        end
        wq_cnt_d  = wq_cnt_q + CW'(aw_acc) - CW'(w_pop);
        bq_cnt_d  = bq_cnt_q + CW'(w_pop) - CW'(b_pop);
        out_cnt_d = out_cnt_q + CW'(aw_acc) - CW'(b_pop);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_valid_q <= 1'b0;
            prio_q     <= 1'b0;
            out_cnt_q  <= '0;
            wq_rd_q    <= '0;
            wq_wr_q    <= '0;
            wq_cnt_q   <= '0;
            bq_rd_q    <= '0;
            bq_wr_q    <= '0;
            bq_cnt_q   <= '0;
        end else begin
            aw_valid_q <= aw_valid_d;
            prio_q     <= prio_d;
            out_cnt_q  <= out_cnt_d;
            wq_rd_q    <= wq_rd_d;
            wq_wr_q    <= wq_wr_d;
            wq_cnt_q   <= wq_cnt_d;
            bq_rd_q    <= bq_rd_d;
            bq_wr_q    <= bq_wr_d;
            bq_cnt_q   <= bq_cnt_d;
        end
    end

    // Payload and queue storage are only read behind a valid flag or a non-zero count
    always_ff @(posedge aclk) begin
        aw_q     <= aw_d;
        wq_mem_q <= wq_mem_d;
        bq_mem_q <= bq_mem_d;
    end

    assign s0_axi.awready = aw_acc && !grant;
    assign s1_axi.awready = aw_acc && grant;
    assign {m_axi.awid, m_axi.awlen, m_axi.awsize, m_axi.awburst,
            m_axi.awcache, m_axi.awaddr} = aw_q;
    assign m_axi.awvalid  = aw_valid_q;

    assign m_axi.wid      = w_head ? s1_axi.wid   : s0_axi.wid;
    assign m_axi.wstrb    = w_head ? s1_axi.wstrb : s0_axi.wstrb;
    assign m_axi.wlast    = w_last;
    assign m_axi.wdata    = w_head ? s1_axi.wdata : s0_axi.wdata;
    assign m_axi.wvalid   = w_vld;
    assign s0_axi.wready  = w_ne && !w_head && m_axi.wready;
    assign s1_axi.wready  = w_ne && w_head && m_axi.wready;

    assign m_axi.bready   = b_rdy;
    assign s0_axi.bvalid  = b_ne && !b_head && m_axi.bvalid;
    assign s1_axi.bvalid  = b_ne && b_head && m_axi.bvalid;
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based model of the arbitration rules.
module tb_axi_write_arbiter;
    localparam int IDW = 6;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int QD  = 4;

    logic aclk;
    logic aresetn;

    axi_write_arbiter_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) s0_if ();
    axi_write_arbiter_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) s1_if ();
    axi_write_arbiter_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) m_if ();

    axi_write_arbiter #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .QUEUE_DEPTH(QD)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s0_axi (s0_if),
        .s1_axi (s1_if),
        .m_axi  (m_if)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference model: owners of outstanding bursts kept as plain queues
    bit          m_aw_v;
    logic [18:0] m_aw_ctl;
    logic [31:0] m_aw_addr;
    bit          prio;
    int          outst;
    logic [0:0]  wq[$];
    logic [0:0]  bq[$];
    logic [63:0] exp_q[$];

    task automatic sample();
        bit any, g, acc, wh, bh, ewv, ewl, ebr, w_pop, b_pop;
        #1;
        any = s0_if.awvalid || s1_if.awvalid;
        g   = (s0_if.awvalid && s1_if.awvalid) ? prio : s1_if.awvalid;
        acc = aresetn && any && (!m_aw_v || m_if.awready) && (outst < QD);
        check("s0_awready", s0_if.awready, acc && !g);
        check("s1_awready", s1_if.awready, acc && g);
        check("m_awvalid", m_if.awvalid, m_aw_v);
        if (m_aw_v) begin
            check("m_awaddr", m_if.awaddr, m_aw_addr);
            check("m_aw_ctl", {m_if.awid, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awcache},
                  m_aw_ctl);
        end
        w_pop = 1'b0;
        if (wq.size() != 0) begin
            wh  = wq[0];
            ewv = wh ? s1_if.wvalid : s0_if.wvalid;
            ewl = wh ? s1_if.wlast : s0_if.wlast;
            check("m_wvalid", m_if.wvalid, ewv);
            check("s0_wready", s0_if.wready, !wh && m_if.wready);
            check("s1_wready", s1_if.wready, wh && m_if.wready);
            if (ewv) begin
                check("m_wdata", m_if.wdata, wh ? s1_if.wdata : s0_if.wdata);
                check("m_w_ctl", {m_if.wid, m_if.wstrb, m_if.wlast},
                      wh ? {s1_if.wid, s1_if.wstrb, s1_if.wlast}
                         : {s0_if.wid, s0_if.wstrb, s0_if.wlast});
            end
            w_pop = ewv && m_if.wready && ewl;
        end else begin
            check("m_wvalid_empty", m_if.wvalid, 1'b0);
            check("s_wready_empty", {s0_if.wready, s1_if.wready}, 2'b00);
        end
        b_pop = 1'b0;
        if (bq.size() != 0) begin
            bh  = bq[0];
            ebr = bh ? s1_if.bready : s0_if.bready;
            check("s0_bvalid", s0_if.bvalid, !bh && m_if.bvalid);
            check("s1_bvalid", s1_if.bvalid, bh && m_if.bvalid);
            check("m_bready", m_if.bready, ebr);
            b_pop = ebr && m_if.bvalid;
        end else begin
            check("m_bready_empty", m_if.bready, 1'b0);
            check("s_bvalid_empty", {s0_if.bvalid, s1_if.bvalid}, 2'b00);
        end
        if (!aresetn) begin
            m_aw_v = 1'b0;
            prio   = 1'b0;
            outst  = 0;
            wq.delete();
            bq.delete();
        end else begin
            if (b_pop) begin
                void'(bq.pop_front());
                outst--;
            end
            if (w_pop) bq.push_back(wq.pop_front());
            if (acc) begin
                wq.push_back(g);
                outst++;
                prio      = !g;
                m_aw_v    = 1'b1;
                m_aw_addr = g ? s1_if.awaddr : s0_if.awaddr;
                m_aw_ctl  = g ? {s1_if.awid, s1_if.awlen, s1_if.awsize, s1_if.awburst, s1_if.awcache}
                              : {s0_if.awid, s0_if.awlen, s0_if.awsize, s0_if.awburst, s0_if.awcache};
            end else if (m_if.awready) begin
                m_aw_v = 1'b0;
            end
        end
    endtask

    // driver tasks
    task automatic advance();
        @(negedge aclk);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        s0_if.awvalid = 0; s1_if.awvalid = 0;
        s0_if.wvalid  = 0; s1_if.wvalid  = 0;
        s0_if.wlast   = 0; s1_if.wlast   = 0;
        s0_if.bready  = 0; s1_if.bready  = 0;
        m_if.awready  = 0; m_if.wready   = 0; m_if.bvalid = 0;
    endtask

    task automatic set_aw(input bit idx, input logic [31:0] addr, input logic [5:0] id);
        if (idx) begin
            s1_if.awaddr = addr; s1_if.awid = id; s1_if.awlen = 4'hF;
            s1_if.awsize = 3'd3; s1_if.awburst = 2'd1; s1_if.awcache = 4'h3;
        end else begin
            s0_if.awaddr = addr; s0_if.awid = id; s0_if.awlen = 4'h0;
            s0_if.awsize = 3'd2; s0_if.awburst = 2'd1; s0_if.awcache = 4'h2;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        int gidx, n_acc, k0, k1;
        logic [63:0] e;
        idle_inputs();
        s0_if.wid = 6'h0A; s1_if.wid = 6'h1B; s0_if.wstrb = 8'hFF; s1_if.wstrb = 8'h0F;
        s0_if.wdata = '0; s1_if.wdata = '0;
        set_aw(0, 32'h0, 6'h0);
        set_aw(1, 32'h0, 6'h0);
        aresetn = 1'b0;
        advance();
        advance();
        do_reset();

        // round-robin from reset: s0, s1, s0, s1
        set_aw(0, 32'h0000_1000, 6'h01);
        set_aw(1, 32'h0000_2000, 6'h02);
        s0_if.awvalid = 1; s1_if.awvalid = 1; m_if.awready = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            gidx = s1_if.awready ? 1 : (s0_if.awready ? 0 : 2);
            check("rr_grant", gidx, i % 2);
            advance();
        end
        s0_if.awvalid = 0; s1_if.awvalid = 0;
        sample();
        check("rr_last_addr", m_if.awaddr, 32'h0000_2000);
        advance();

        // s1 address first: all s1 beats precede s0 beats
        do_reset();
        m_if.awready = 1;
        set_aw(1, 32'h0000_B000, 6'h11);
        s1_if.awvalid = 1;
        tick();
        s1_if.awvalid = 0;
        set_aw(0, 32'h0000_A000, 6'h10);
        s0_if.awvalid = 1;
        tick();
        s0_if.awvalid = 0;
        for (int k = 0; k < 16; k++) exp_q.push_back(64'hB100_0000 + 64'(k));
        for (int k = 0; k < 16; k++) exp_q.push_back(64'hA000_0000 + 64'(k));
        k0 = 0; k1 = 0;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            s0_if.wvalid = (k0 < 16); s0_if.wdata = 64'hA000_0000 + 64'(k0); s0_if.wlast = (k0 == 15);
            s1_if.wvalid = (k1 < 16); s1_if.wdata = 64'hB100_0000 + 64'(k1); s1_if.wlast = (k1 == 15);
            m_if.wready = ($urandom_range(0, 3) != 0);
            sample();
            if (k1 < 16) check("s0_wready_blocked", s0_if.wready, 1'b0);
            if (m_if.wvalid && m_if.wready) begin
                e = exp_q.pop_front();
                check("w_order", m_if.wdata, e);
                check("w_last_beat", m_if.wlast, e[3:0] == 4'hF);
            end
            if (s0_if.wvalid && s0_if.wready) k0++;
            if (s1_if.wvalid && s1_if.wready) k1++;
            advance();
        end
        check("w_drain", exp_q.size(), 0);
        s0_if.wvalid = 0; s1_if.wvalid = 0;

        // outstanding limit with B held off
        do_reset();
        m_if.awready = 1; m_if.wready = 1; s0_if.bready = 1;
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            set_aw(0, 32'h0000_3000 + 32'(n_acc * 16), 6'h05);
            s0_if.awvalid = 1; s0_if.wvalid = 1; s0_if.wlast = 1; s0_if.wdata = 64'(n_acc);
            sample();
            if (s0_if.awready) n_acc++;
            advance();
        end
        check("aw_accept_limit", n_acc, QD);
        m_if.bvalid = 1;
        sample();
        check("b_handshake", m_if.bready, 1'b1);
        check("aw_blocked_on_bpop", s0_if.awready, 1'b0);
        advance();
        m_if.bvalid = 0;
        sample();
        check("aw_after_bpop", s0_if.awready, 1'b1);
        advance();
        s0_if.awvalid = 0; s0_if.wvalid = 0;

        // back-pressure on the AW stage
        do_reset();
        m_if.awready = 0;
        set_aw(0, 32'h0000_4440, 6'h07);
        s0_if.awvalid = 1;
        tick();
        set_aw(0, 32'h0000_5550, 6'h08);
        set_aw(1, 32'h0000_6660, 6'h09);
        s1_if.awvalid = 1;
        for (int c = 0; c < 5; c++) begin
            sample();
            check("aw_hold_addr", m_if.awaddr, 32'h0000_4440);
            check("aw_hold_valid", m_if.awvalid, 1'b1);
            check("aw_hold_ready", {s0_if.awready, s1_if.awready}, 2'b00);
            advance();
        end
        m_if.awready = 1;
        tick();
        s0_if.awvalid = 0; s1_if.awvalid = 0;
        tick();

        // B routing in completion order, then reset mid-burst
        do_reset();
        m_if.awready = 1; m_if.wready = 1;
        set_aw(0, 32'h0000_7000, 6'h0C); s0_if.awvalid = 1;
        tick();
        s0_if.awvalid = 0;
        set_aw(1, 32'h0000_8000, 6'h0D); s1_if.awvalid = 1;
        tick();
        s1_if.awvalid = 0;
        s0_if.wvalid = 1; s0_if.wlast = 1; s1_if.wvalid = 1; s1_if.wlast = 1;
        tick();
        tick();
        s0_if.wvalid = 0; s1_if.wvalid = 0;
        s0_if.bready = 1; s1_if.bready = 1; m_if.bvalid = 1;
        sample();
        check("b_first_route", {s0_if.bvalid, s1_if.bvalid}, 2'b10);
        advance();
        m_if.bvalid = 0;
        tick();
        m_if.bvalid = 1;
        sample();
        check("b_second_route", {s0_if.bvalid, s1_if.bvalid}, 2'b01);
        advance();
        m_if.bvalid = 0;
        set_aw(0, 32'h0000_9000, 6'h0E); s0_if.awvalid = 1;
        tick();
        s0_if.wvalid = 1; s0_if.wlast = 0; m_if.bvalid = 1;
        tick();
        aresetn = 1'b0;
        tick();
        sample();
        check("reset_mid_burst", {s0_if.awready, s1_if.awready, s0_if.wready, s1_if.wready,
                                  s0_if.bvalid, s1_if.bvalid, m_if.awvalid, m_if.wvalid,
                                  m_if.bready}, 9'h000);
        advance();
        aresetn = 1'b1;
        idle_inputs();
        tick();

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            aresetn       = ($urandom_range(0, 249) != 0);
            s0_if.awvalid = $urandom_range(0, 1);
            s1_if.awvalid = $urandom_range(0, 1);
            set_aw(0, $urandom, 6'($urandom));
            set_aw(1, $urandom, 6'($urandom));
            s0_if.wvalid  = ($urandom_range(0, 9) < 7);
            s1_if.wvalid  = ($urandom_range(0, 9) < 7);
            s0_if.wlast   = ($urandom_range(0, 2) == 0);
            s1_if.wlast   = ($urandom_range(0, 2) == 0);
            s0_if.wdata   = {$urandom, $urandom};
            s1_if.wdata   = {$urandom, $urandom};
            s0_if.wstrb   = 8'($urandom);
            s1_if.wstrb   = 8'($urandom);
            s0_if.wid     = 6'($urandom);
            s1_if.wid     = 6'($urandom);
            s0_if.bready  = ($urandom_range(0, 9) < 7);
            s1_if.bready  = ($urandom_range(0, 9) < 7);
            m_if.awready  = ($urandom_range(0, 9) < 7);
            m_if.wready   = ($urandom_range(0, 9) < 7);
            m_if.bvalid   = ($urandom_range(0, 9) < 3);
            tick();
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
